// File: rtl/fifo_pop_streamer.sv
// Pops a non-showahead FIFO read port and re-presents the words as a valid/ready stream,
// with flush sequencing and a sticky protocol-error flag. Optional counters: FIFO_POP_STREAMER_STATS_EN.
module fifo_pop_streamer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  output logic                  pop_enable,
  input  logic                  pop_empty,
  input  logic                  pop_valid,
  input  logic [DATA_WIDTH-1:0] pop_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  flush_done,
  output logic                  error,
  output logic [31:0]           stat_words,
  output logic [31:0]           stat_stall
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      credit_c;
  logic                  outstanding_q;
  logic                  pop_en_q;
  logic                  armed_q;
  logic                  error_q;
  logic                  wr_en;
  logic                  rd_en;
  logic                  buf_clear;

  // Buffered words plus the one possibly in flight must fit in the buffer.
  assign credit_c = count_q + CNT_W'(outstanding_q);

  // Next-state and the combinational stream/pop controls derived from registered state.
  always_comb begin
    state_d    = state_q;
    pop_enable = 1'b0;
    out_valid  = 1'b0;
    flush_done = 1'b0;
    buf_clear  = 1'b0;
    case (state_q)
      ST_RUN: begin
        pop_enable = armed_q & ~pop_empty & (credit_c < DEPTH_CNT);
        out_valid  = (count_q != '0);
        if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!outstanding_q) begin
          buf_clear = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        flush_done = 1'b1;
        state_d    = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign rd_en    = out_valid & out_ready;
  assign wr_en    = (state_q == ST_RUN) & pop_valid & (count_q != DEPTH_CNT);
  assign out_data = buf_q[rd_ptr_q];
  assign error    = error_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Storage is reset so out_data reads zero straight out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else if (wr_en) begin
      buf_q[wr_ptr_q] <= pop_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (buf_clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Pops are held off until the first edge after reset so pop_enable stays low during reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed_q       <= 1'b0;
      pop_en_q      <= 1'b0;
      outstanding_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      armed_q  <= 1'b1;
      pop_en_q <= pop_enable;
      if (pop_enable) begin
        outstanding_q <= 1'b1;
      end else if (pop_valid) begin
        outstanding_q <= 1'b0;
      end
      if (pop_valid & ~outstanding_q & ~pop_en_q) begin
        error_q <= 1'b1;
      end
    end
  end

`ifdef FIFO_POP_STREAMER_STATS_EN
  logic [31:0] words_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      if (rd_en) begin
        words_q <= words_q + 32'd1;
      end
      if (out_valid & ~out_ready) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign stat_words = words_q;
  assign stat_stall = stall_q;
`else
  assign stat_words = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_fifo_pop_streamer.sv
// Randomized bench for fifo_pop_streamer: a queue-based FIFO model drives the read port and a
// queue-level reference of the buffered words predicts every stream output cycle by cycle.
module tb_fifo_pop_streamer;

  localparam int unsigned DW = 32;
  localparam int unsigned BD = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          pop_enable;
  logic          pop_empty;
  logic          pop_valid;
  logic [DW-1:0] pop_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          flush_done;
  logic          error;
  logic [31:0]   stat_words;
  logic [31:0]   stat_stall;

  fifo_pop_streamer #(.DATA_WIDTH(DW), .BUF_DEPTH(BD)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .pop_enable (pop_enable),
    .pop_empty  (pop_empty),
    .pop_valid  (pop_valid),
    .pop_data   (pop_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .flush_done (flush_done),
    .error      (error),
    .stat_words (stat_words),
    .stat_stall (stat_stall)
  );

  always #5 clk = ~clk;

  // FIFO contents and reference model state
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] m_buf[$];
  int            m_mode;       // 0 run, 1 drain, 2 done
  bit            m_out, m_prev_pe, m_err, m_armed;
  int unsigned   m_words, m_stall;

  bit  nxt_ready, nxt_flush, nxt_inject, force_empty;
  int  vectors, miscompares, cyc;
  int  pe_run, pe_run_max, pe_total, first_pe_cyc, first_val_cyc;
  int  hs_count, stall_obs, done_pulses;
  bit  cap_armed;
  logic [DW-1:0] cap_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic load(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + DW'(i));
    pop_empty = force_empty || (fifo_q.size() == 0);
  endtask

  // One clock cycle: check at negedge, advance the model at posedge, drive next inputs.
  task automatic step();
    bit e_pe, e_val, full, dut_pe, smp_empty;
    @(negedge clk);
    e_pe  = m_armed && (m_mode == 0) && !pop_empty && ((m_buf.size() + int'(m_out)) < int'(BD));
    e_val = (m_mode == 0) && (m_buf.size() != 0);
    check("pop_enable", pop_enable, e_pe);
    check("out_valid", out_valid, e_val);
    if (e_val) check("out_data", out_data, m_buf[0]);
    check("flush_done", flush_done, m_mode == 2);
    check("error", error, m_err);
    dut_pe    = pop_enable;
    smp_empty = pop_empty;
    if (pop_enable) begin
      pe_run++;
      pe_total++;
      if (pe_run > pe_run_max) pe_run_max = pe_run;
      if (first_pe_cyc < 0) first_pe_cyc = cyc;
    end else begin
      pe_run = 0;
    end
    if (out_valid && first_val_cyc < 0) first_val_cyc = cyc;
    if (out_valid && out_ready) hs_count++;
    if (out_valid && !out_ready) stall_obs++;
    if (flush_done) done_pulses++;
    if (cap_armed && out_valid) begin
      cap_data  = out_data;
      cap_armed = 0;
    end

    @(posedge clk);
    cyc++;
    if (pop_valid && !m_out && !m_prev_pe) m_err = 1;
    case (m_mode)
      0: begin
        full = (m_buf.size() == int'(BD));
        if (e_val && out_ready) begin
          void'(m_buf.pop_front());
          m_words++;
        end
        if (e_val && !out_ready) m_stall++;
        if (pop_valid && !full) m_buf.push_back(pop_data);
        if (flush) m_mode = 1;
      end
      1: begin
        if (!m_out) begin
          m_buf.delete();
          m_mode = 2;
        end
      end
      default: m_mode = 0;
    endcase
    if (e_pe) m_out = 1;
    else if (pop_valid) m_out = 0;
    m_prev_pe = e_pe;
    m_armed   = 1;

    #1;
    if (dut_pe && !smp_empty && fifo_q.size() != 0) begin
      pop_valid = 1'b1;
      pop_data  = fifo_q.pop_front();
    end else if (nxt_inject) begin
      pop_valid = 1'b1;
      pop_data  = {24'hBAD000, 8'($urandom)};
    end else begin
      pop_valid = 1'b0;
      pop_data  = $urandom;
    end
    nxt_inject = 0;
    pop_empty  = force_empty || (fifo_q.size() == 0);
    out_ready  = nxt_ready;
    flush      = nxt_flush;
    nxt_flush  = 0;
  endtask

  // Asynchronous reset: outputs must be back at reset values before any clock edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_pop_enable", pop_enable, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_error", error, 0);
    check("rst_stat_words", stat_words, 0);
    check("rst_stat_stall", stat_stall, 0);
    fifo_q.delete();
    force_empty = 0; nxt_ready = 0; nxt_flush = 0; nxt_inject = 0; cap_armed = 0;
    pop_valid = 0; pop_empty = 1; flush = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_buf.delete();
    m_mode = 0; m_out = 0; m_prev_pe = 0; m_err = 0; m_armed = 0; m_words = 0; m_stall = 0;
    pe_run = 0; pe_run_max = 0; pe_total = 0; first_pe_cyc = -1; first_val_cyc = -1;
    hs_count = 0; stall_obs = 0; done_pulses = 0; cyc = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    bit found;
    int seq;
    vectors = 0; miscompares = 0;
    reset_n = 1'b1; flush = 0; pop_empty = 1; pop_valid = 0; pop_data = '0; out_ready = 0;
    #2;
    do_reset();

    // Full-rate stream of 16 words
    load(16, 32'h0);
    nxt_ready = 1; out_ready = 1;
    repeat (24) step();
    check("t1_pop_run", pe_run_max, 16);
    check("t1_latency", first_val_cyc - first_pe_cyc, 2);
    check("t1_words", hs_count, 16);
`ifdef FIFO_POP_STREAMER_STATS_EN
    check("t1_stat_words", stat_words, 16);
`else
    check("t1_stat_words", stat_words, 0);
`endif

    // Back-pressure for 10 valid cycles, then released
    do_reset();
    load(16, 32'h0);
    for (int i = 0; i < 60; i++) begin
      step();
      if (m_stall >= 9) nxt_ready = 1;
    end
    check("t2_words", hs_count, 16);
    check("t2_stalls", stall_obs, 10);
`ifdef FIFO_POP_STREAMER_STATS_EN
    check("t2_stat_stall", stat_stall, 10);
`else
    check("t2_stat_stall", stat_stall, 0);
`endif

    // FIFO runs empty mid-stream for 5 cycles
    do_reset();
    load(20, 32'h200);
    nxt_ready = 1; out_ready = 1;
    repeat (6) step();
    force_empty = 1; pop_empty = 1;
    seq = pe_total;
    repeat (5) step();
    check("t3_no_pop_while_empty", pe_total - seq, 0);
    force_empty = 0; pop_empty = (fifo_q.size() == 0);
    repeat (30) step();
    check("t3_words", hs_count, 20);
    check("t3_error", error, 0);

    // Flush with 3 buffered words and one in flight
    do_reset();
    load(40, 32'h100);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (m_mode == 0 && m_buf.size() == 3 && m_out) found = 1;
    end
    check("t4_setup_reached", found, 1);
    flush = 1;
    done_pulses = 0;
    hs_count = 0;
    repeat (6) step();
    check("t4_flush_done_once", done_pulses, 1);
    cap_armed = 1;
    nxt_ready = 1;
    repeat (60) step();
    check("t4_first_after_flush", cap_data, 32'h104);
    check("t4_words_after_flush", hs_count, 36);

    // Randomized traffic with random stalls, empties and flushes
    do_reset();
    seq = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      if (fifo_q.size() < 8 && ($urandom % 4) == 0) begin
        load(int'($urandom_range(1, 6)), DW'(seq));
        seq += 8;
      end
      nxt_ready   = ($urandom % 4) != 0;
      force_empty = ($urandom % 8) == 0;
      nxt_flush   = ($urandom % 40) == 0;
      step();
    end
    force_empty = 0; nxt_ready = 1;
    repeat (30) step();
    check("t5_error", error, 0);
`ifdef FIFO_POP_STREAMER_STATS_EN
    check("t5_stat_words", stat_words, m_words);
    check("t5_stat_stall", stat_stall, m_stall);
`else
    check("t5_stat_words", stat_words, 0);
`endif

    // Spurious pop_valid sets a sticky error
    do_reset();
    force_empty = 1; pop_empty = 1; nxt_ready = 1;
    repeat (3) step();
    nxt_inject = 1;
    repeat (12) step();
    check("t6_error_sticky", error, 1);
    do_reset();
    repeat (2) step();
    check("t6_error_cleared", error, 0);

    // Reset asserted mid-stream
    load(20, 32'h300);
    nxt_ready = 1; out_ready = 1;
    repeat (8) step();
    do_reset();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_pop_streamer.md
# fifo_pop_streamer

Single-clock consumer that sits directly on the read side of the async FIFO channel, in the FIFO's read-clock domain. It issues pop requests against the FIFO's non-showahead read port and absorbs the 1-cycle pop-to-data latency in a small credit-managed buffer. It presents the words downstream as a valid/ready stream with full 1-word/cycle throughput. It also provides a flush sequence and a sticky protocol-error flag.

## Interface
- DATA_WIDTH, 32, word width; equals the FIFO's DATA_WIDTH.
- BUF_DEPTH, 4, local buffer entries; power of two, minimum 4 (≥3 needed for full throughput).
- clk  in  1  sole clock; same clock as the FIFO read side.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  single-cycle request to discard buffered and in-flight words.
- pop_enable  out  1  read request to FIFO.
- pop_empty  in  1  FIFO read-side empty.
- pop_valid  in  1  FIFO says pop_data carries a word this cycle.
- pop_data  in  DATA_WIDTH  FIFO read data.
- out_valid  out  1  stream word available.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  stream word.
- flush_done  out  1  one-cycle pulse at flush completion.
- error  out  1  sticky protocol error.
- stat_words  out  32  words delivered downstream (see Configuration).
- stat_stall  out  32  cycles with out_valid & ~out_ready (see Configuration).

## Operation
- Reset values: pop_enable=0, out_valid=0, out_data=0, flush_done=0, error=0, stats=0, state=RUN, buffer empty, outstanding=0.
- Buffer: circular, wr/rd pointers log2(BUF_DEPTH) bits with natural wrap; count register is log2(BUF_DEPTH)+1 bits.
- outstanding: 0/1 register. It is set on the cycle pop_enable=1. It is cleared on the cycle pop_valid=1 if no new pop_enable is issued that cycle.
- Write: any cycle with pop_valid=1 in RUN writes pop_data at wr_ptr.
- Read: out_valid=1 whenever count≠0 in RUN. out_data is the word at rd_ptr. The handshake out_valid & out_ready advances rd_ptr.
- Simultaneous write and read: count is unchanged and both pointers advance.
- Credit rule: pop_enable = (state==RUN) & ~pop_empty & (count + outstanding < BUF_DEPTH). It is combinational from registered state, so the buffer can never overflow.
- FSM states:
  - RUN: normal operation. flush=1 moves to DRAIN.
  - DRAIN: pop_enable=0 and out_valid=0. Words arriving on pop_valid are discarded. When outstanding==0, the buffer is cleared (pointers and count to 0) and the FSM moves to DONE.
  - DONE: flush_done=1 for one cycle, then back to RUN.
- flush outside RUN is ignored. A flush in the same cycle as a handshake still completes that handshake.
- Error: sticky set when pop_valid=1 while outstanding==0 and no pop_enable was issued the previous cycle. It is cleared only by reset_n.
- A reset mid-transfer drops all state immediately. In-flight FIFO words are lost; the FIFO is expected to be cleared alongside.

## Timing
- pop_enable in cycle t → pop_valid/pop_data in cycle t+1 → out_valid in cycle t+2 (2-cycle FIFO-to-stream latency).
- Sustained throughput is 1 word/cycle with out_ready held high and pop_empty low.
- After out_ready falls, at most one further word arrives. Buffer capacity covers it.
- Flush: flush sampled at edge t. DRAIN starts at t+1 (out_valid low, pop_enable low). flush_done pulses 1–2 cycles later, depending on outstanding.
- Boundaries:
  - count==BUF_DEPTH: pop_enable=0.
  - count==BUF_DEPTH-1 with outstanding=1: pop_enable=0.
  - pop_empty=1: no pop issued.

## Configuration
- FIFO_POP_STREAMER_STATS_EN defined: stat_words increments on each handshake and stat_stall on each stalled cycle. Both are 32-bit, wrap modulo 2^32, and reset to 0.
- Not defined: both counters are absent and the stat ports are tied to 0.

## Test plan
- Preload FIFO with 16 words 0x0..0xF, out_ready=1 → pop_enable high for 16 consecutive cycles; out_data 0x0..0xF on 16 consecutive cycles starting 2 cycles after the first pop; stat_words=16.
- Same 16 words, out_ready low for 10 cycles then high → pop_enable drops once count+outstanding=4; no word lost or duplicated; stat_stall=10 after the first out_valid.
- FIFO empties mid-stream (pop_empty=1 for 5 cycles) → no pop issued while empty; stream resumes in order with no error.
- flush with 3 buffered words and outstanding=1 → out_valid drops the next cycle; flush_done pulses exactly once; next FIFO word appears on out_data with no stale data.
- Inject pop_valid=1 with no prior pop_enable → error=1 and stays high until reset_n is asserted.
- Assert reset_n=0 mid-stream → all outputs return to reset values asynchronously, before the next clock edge.
